// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin two-requester transaction sequencer for the SPI byte engine,
// with a chip-select-high gap between transactions and an engine watchdog.
`timescale 1ns/1ps
module spi_master_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       sysClk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic [7:0] byte0_i,
  input  logic [7:0] byte1_i,
  input  logic [1:0] last_i,
  output logic [1:0] gnt_o,
  output logic [1:0] byte_ack_o,
  output logic [7:0] rx_data_o,
  output logic [1:0] rx_valid_o,
  output logic       err_o,
  output logic       eng_start_o,
  output logic [7:0] eng_tx_o,
  output logic       eng_cs_n_o,
  input  logic       eng_done_i,
  input  logic [7:0] eng_rx_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
  state_t      state_q;
  logic        ptr_q, g_q, last_q;
  logic [7:0]  gap_q;
  logic [15:0] wd_q;
  logic        sel, timeout;
  assign sel     = (req_i == 2'b11) ? ptr_q : req_i[1];
  // A zero timeout disables the watchdog entirely.
  assign timeout = (TIMEOUT_CYCLES != 0) && (wd_q == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge sysClk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      g_q         <= 1'b0;
      last_q      <= 1'b0;
      gap_q       <= '0;
      wd_q        <= '0;
      gnt_o       <= '0;
      byte_ack_o  <= '0;
      rx_valid_o  <= '0;
      rx_data_o   <= '0;
      err_o       <= 1'b0;
      eng_start_o <= 1'b0;
      eng_tx_o    <= '0;
      eng_cs_n_o  <= 1'b1;
    end else begin
      byte_ack_o  <= '0;
      rx_valid_o  <= '0;
      err_o       <= 1'b0;
      eng_start_o <= 1'b0;
      case (state_q)
        IDLE: if (|req_i) begin
          g_q        <= sel;
          gnt_o      <= sel ? 2'b10 : 2'b01;
          eng_cs_n_o <= 1'b0;
          state_q    <= ISSUE;
        end
        ISSUE: if (!req_i[g_q]) begin
          eng_cs_n_o <= 1'b1;
          gnt_o      <= '0;
          gap_q      <= 8'(GAP_CYCLES - 1);
          state_q    <= GAP;
        end else begin
          eng_tx_o    <= g_q ? byte1_i : byte0_i;
          last_q      <= last_i[g_q];
          eng_start_o <= 1'b1;
          byte_ack_o  <= g_q ? 2'b10 : 2'b01;
          wd_q        <= '0;
          state_q     <= WAIT;
        end
        WAIT: if (eng_done_i) begin
          rx_data_o  <= eng_rx_i;
          rx_valid_o <= g_q ? 2'b10 : 2'b01;
          if (last_q) begin
            eng_cs_n_o <= 1'b1;
            gnt_o      <= '0;
            ptr_q      <= ~g_q;
            gap_q      <= 8'(GAP_CYCLES - 1);
            state_q    <= GAP;
          end else begin
            state_q <= ISSUE;
          end
        end else if (timeout) begin
          err_o      <= 1'b1;
          eng_cs_n_o <= 1'b1;
          gnt_o      <= '0;
          ptr_q      <= ~g_q;
          gap_q      <= 8'(GAP_CYCLES - 1);
          state_q    <= GAP;
        end else begin
          wd_q <= wd_q + 16'd1;
        end
        GAP: if (gap_q == 8'd0) state_q <= IDLE;
             else gap_q <= gap_q - 8'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed scenario tasks for the two-requester SPI arbiter.
`timescale 1ns/1ps
module tb_spi_master_arbiter;
  localparam int GAP = 4;
  localparam int TO  = 20;
  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [1:0] req_i = '0;
  logic [7:0] byte0_i = '0, byte1_i = '0;
  logic [1:0] last_i = '0;
  logic [1:0] gnt_o, byte_ack_o, rx_valid_o;
  logic [7:0] rx_data_o, eng_tx_o;
  logic       err_o, eng_start_o, eng_cs_n_o;
  logic       eng_done_i = 1'b0;
  logic [7:0] eng_rx_i = '0;
  int checks = 0, passes = 0;

  spi_master_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .sysClk_i(clk), .reset_i(reset_i), .req_i(req_i), .byte0_i(byte0_i), .byte1_i(byte1_i),
    .last_i(last_i), .gnt_o(gnt_o), .byte_ack_o(byte_ack_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .err_o(err_o), .eng_start_o(eng_start_o), .eng_tx_o(eng_tx_o),
    .eng_cs_n_o(eng_cs_n_o), .eng_done_i(eng_done_i), .eng_rx_i(eng_rx_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle(2);
    checks++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt got %b want 00", gnt_o); else passes++;
    checks++; if (eng_cs_n_o !== 1'b1) $display("FAIL reset_cs got %b want 1", eng_cs_n_o); else passes++;
    checks++; if ({byte_ack_o, rx_valid_o, err_o, eng_start_o} !== 6'b0)
      $display("FAIL reset_pulses got %b want 000000", {byte_ack_o, rx_valid_o, err_o, eng_start_o}); else passes++;
    checks++; if ({eng_tx_o, rx_data_o} !== 16'h0) $display("FAIL reset_data got %h want 0000", {eng_tx_o, rx_data_o}); else passes++;
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_i = 2'b01; byte0_i = 8'hA5; last_i = 2'b01;
    tick();
    checks++; if ({gnt_o, eng_cs_n_o, eng_start_o} !== 4'b0100)
      $display("FAIL single_grant got gnt=%b cs=%b st=%b want 01/0/0", gnt_o, eng_cs_n_o, eng_start_o); else passes++;
    tick();
    checks++; if ({eng_start_o, byte_ack_o, eng_tx_o} !== {1'b1, 2'b01, 8'hA5})
      $display("FAIL single_start got st=%b ack=%b tx=%h want 1/01/a5", eng_start_o, byte_ack_o, eng_tx_o); else passes++;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++; if ({rx_valid_o, eng_cs_n_o, eng_start_o} !== 4'b0000)
        $display("FAIL single_wait cyc %0d got rv=%b cs=%b st=%b want 00/0/0", i, rx_valid_o, eng_cs_n_o, eng_start_o); else passes++;
    end
    eng_done_i = 1'b1; eng_rx_i = 8'h3C;
    tick();
    eng_done_i = 1'b0;
    checks++; if ({rx_valid_o, rx_data_o, eng_cs_n_o, gnt_o} !== {2'b01, 8'h3C, 1'b1, 2'b00})
      $display("FAIL single_done got rv=%b d=%h cs=%b gnt=%b want 01/3c/1/00", rx_valid_o, rx_data_o, eng_cs_n_o, gnt_o); else passes++;
    // Re-request immediately: ignored during GAP, granted GAP+1 edges after CS rose.
    req_i = 2'b01;
    idle(GAP);
    checks++; if ({gnt_o, eng_cs_n_o} !== 3'b001) $display("FAIL single_gap got gnt=%b cs=%b want 00/1", gnt_o, eng_cs_n_o); else passes++;
    tick();
    checks++; if ({gnt_o, eng_cs_n_o} !== 3'b010) $display("FAIL single_regrant got gnt=%b cs=%b want 01/0", gnt_o, eng_cs_n_o); else passes++;
    req_i = 2'b00;
    tick();
    checks++; if ({eng_start_o, byte_ack_o, gnt_o, eng_cs_n_o} !== 6'b000001)
      $display("FAIL withdraw got st=%b ack=%b gnt=%b cs=%b want 0/00/00/1", eng_start_o, byte_ack_o, gnt_o, eng_cs_n_o); else passes++;
    idle(GAP + 2);
    eng_done_i = 1'b1; eng_rx_i = 8'hFF;
    tick();
    eng_done_i = 1'b0;
    checks++; if ({rx_valid_o, rx_data_o} !== {2'b00, 8'h3C})
      $display("FAIL stray_done got rv=%b d=%h want 00/3c", rx_valid_o, rx_data_o); else passes++;
    tick();
  endtask

  task automatic test_multi();
    logic [7:0] tx [3];
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    req_i = 2'b10; byte1_i = tx[0]; last_i = 2'b00;
    tick();
    checks++; if (gnt_o !== 2'b10) $display("FAIL multi_grant got %b want 10", gnt_o); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({eng_start_o, byte_ack_o, eng_tx_o, gnt_o, eng_cs_n_o} !== {1'b1, 2'b10, tx[i], 2'b10, 1'b0})
        $display("FAIL multi_start%0d got st=%b ack=%b tx=%h gnt=%b cs=%b", i, eng_start_o, byte_ack_o, eng_tx_o, gnt_o, eng_cs_n_o); else passes++;
      if (i < 2) begin byte1_i = tx[i+1]; last_i = (i == 1) ? 2'b10 : 2'b00; end
      idle(2);
      checks++; if ({rx_valid_o, gnt_o, eng_cs_n_o} !== 5'b00100)
        $display("FAIL multi_wait%0d got rv=%b gnt=%b cs=%b want 00/10/0", i, rx_valid_o, gnt_o, eng_cs_n_o); else passes++;
      eng_done_i = 1'b1; eng_rx_i = 8'hB0 + 8'(i);
      tick();
      eng_done_i = 1'b0;
      checks++; if ({rx_valid_o, rx_data_o, eng_cs_n_o} !== {2'b10, 8'hB0 + 8'(i), i == 2})
        $display("FAIL multi_rx%0d got rv=%b d=%h cs=%b", i, rx_valid_o, rx_data_o, eng_cs_n_o); else passes++;
    end
    req_i = 2'b00; last_i = 2'b00;
    idle(GAP + 2);
  endtask

  task automatic test_watchdog();
    int n;
    req_i = 2'b01; byte0_i = 8'h5A; last_i = 2'b01;
    idle(2);
    checks++; if (eng_start_o !== 1'b1) $display("FAIL wd_start got %b want 1", eng_start_o); else passes++;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      checks++; if ({err_o, eng_cs_n_o} !== 2'b00) $display("FAIL wd_early cyc %0d got err=%b cs=%b want 0/0", i, err_o, eng_cs_n_o); else passes++;
    end
    tick();
    checks++; if ({err_o, eng_cs_n_o, gnt_o, rx_valid_o} !== 6'b110000)
      $display("FAIL wd_abort got err=%b cs=%b gnt=%b rv=%b want 1/1/00/00", err_o, eng_cs_n_o, gnt_o, rx_valid_o); else passes++;
    req_i = 2'b11;
    n = 0;
    while (gnt_o === 2'b00 && n < 50) begin tick(); n++; end
    checks++; if (gnt_o !== 2'b10) $display("FAIL wd_next_grant got %b want 10", gnt_o); else passes++;
    req_i = 2'b00; last_i = 2'b00;
    idle(GAP + 3);
  endtask

  task automatic test_done_timeout();
    req_i = 2'b10; byte1_i = 8'h77; last_i = 2'b10;
    idle(2);
    idle(TO - 1);
    eng_done_i = 1'b1; eng_rx_i = 8'hE7;
    tick();
    eng_done_i = 1'b0;
    checks++; if ({rx_valid_o, err_o, rx_data_o, eng_cs_n_o} !== {2'b10, 1'b0, 8'hE7, 1'b1})
      $display("FAIL done_vs_timeout got rv=%b err=%b d=%h cs=%b want 10/0/e7/1", rx_valid_o, err_o, rx_data_o, eng_cs_n_o); else passes++;
    req_i = 2'b00; last_i = 2'b00;
    idle(GAP + 2);
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    int n, hi;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    req_i = 2'b11; last_i = 2'b00; byte0_i = 8'h0A; byte1_i = 8'h1B;
    for (int t = 0; t < 4; t++) begin
      exp = t[0] ? 2'b10 : 2'b01;
      n = 0; hi = 1;
      while (gnt_o === 2'b00 && n < 50) begin tick(); n++; if (eng_cs_n_o) hi++; end
      checks++; if (gnt_o !== exp) $display("FAIL cont_grant%0d got %b want %b", t, gnt_o, exp); else passes++;
      if (t > 0) begin
        checks++; if (hi !== GAP + 1) $display("FAIL cont_gap%0d got %0d cycles want %0d", t, hi, GAP + 1); else passes++;
      end
      for (int b = 0; b < 2; b++) begin
        tick();
        checks++; if ({eng_start_o, byte_ack_o} !== {1'b1, exp})
          $display("FAIL cont_start%0d_%0d got st=%b ack=%b want 1/%b", t, b, eng_start_o, byte_ack_o, exp); else passes++;
        last_i[t[0]] = (b == 0);
        tick();
        eng_done_i = 1'b1; eng_rx_i = 8'(t * 16 + b);
        tick();
        eng_done_i = 1'b0;
        checks++; if ({rx_valid_o, rx_data_o, eng_cs_n_o} !== {exp, 8'(t * 16 + b), b == 1})
          $display("FAIL cont_rx%0d_%0d got rv=%b d=%h cs=%b", t, b, rx_valid_o, rx_data_o, eng_cs_n_o); else passes++;
      end
    end
    req_i = 2'b00; last_i = 2'b00;
    idle(GAP + 2);
  endtask

  task automatic test_reset_mid();
    req_i = 2'b01; byte0_i = 8'h01; last_i = 2'b00;
    idle(2);
    byte0_i = 8'h02;
    eng_done_i = 1'b1; eng_rx_i = 8'h44;
    tick();
    eng_done_i = 1'b0;
    tick();
    checks++; if ({eng_start_o, eng_tx_o} !== {1'b1, 8'h02}) $display("FAIL mid_start2 got st=%b tx=%h want 1/02", eng_start_o, eng_tx_o); else passes++;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++; if ({eng_cs_n_o, gnt_o, byte_ack_o, rx_valid_o, err_o, eng_start_o, eng_tx_o} !== {1'b1, 8'h00, 8'h00})
      $display("FAIL mid_reset got cs=%b gnt=%b ack=%b rv=%b err=%b st=%b tx=%h", eng_cs_n_o, gnt_o, byte_ack_o, rx_valid_o, err_o, eng_start_o, eng_tx_o); else passes++;
    req_i = 2'b11;
    tick();
    checks++; if (gnt_o !== 2'b01) $display("FAIL mid_regrant got %b want 01", gnt_o); else passes++;
    req_i = 2'b00;
    idle(GAP + 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_watchdog();
    test_done_timeout();
    test_contention();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
